// File: rtl/riscuinho_pkg.sv
// Shared definitions for the riscuinho core: access sizes, LSU state encoding,
// data bus width and the alignment rule used at load/store acceptance.
package riscuinho_pkg;

    localparam int BUS_W = 32;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_REQ   = 2'd1,
        LSU_DONE  = 2'd2,
        LSU_FAULT = 2'd3
    } lsu_state_t;

    // Size 11 is not a real access width, so it is treated as a fault too.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_B:  is_misaligned = 1'b0;
            SIZE_H:  is_misaligned = addr_lo[0];
            SIZE_W:  is_misaligned = (addr_lo != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for sub-word accesses: byte enables, store data replication,
// and load right-shift with sign/zero extension. Purely combinational.
module lsu_align
    import riscuinho_pkg::*;
(
    input  logic [1:0]       addr_lo,
    input  logic [1:0]       size,
    input  logic             unsigned_value,
    input  logic [BUS_W-1:0] wdata,
    input  logic [BUS_W-1:0] rdata,
    output logic [3:0]       be,
    output logic [BUS_W-1:0] wdata_rep,
    output logic [BUS_W-1:0] rdata_ext
);

    logic [BUS_W-1:0] shifted;

    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        shifted   = rdata;
        rdata_ext = rdata;
        case (size)
            SIZE_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                shifted   = rdata >> {addr_lo, 3'b000};
                rdata_ext = {{24{~unsigned_value & shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                shifted   = rdata >> {addr_lo[1], 4'b0000};
                rdata_ext = {{16{~unsigned_value & shifted[15]}}, shifted[15:0]};
            end
            SIZE_W: begin
                be = 4'b1111;
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: accepts one decoded load/store, runs a single req/ack bus
// transaction and returns the extended load result to the register file.
module load_store_unit
    import riscuinho_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             data_r,
    input  logic             data_w,
    input  logic [1:0]       data_size,
    input  logic             unsigned_value,
    input  logic [4:0]       rd_sel,
    input  logic [BUS_W-1:0] addr,
    input  logic [BUS_W-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             misaligned,
    output logic             bus_err,
    output logic             rd_w,
    output logic [4:0]       rd_sel_out,
    output logic [BUS_W-1:0] rd_data,
    output logic             mem_req,
    output logic             mem_we,
    output logic [BUS_W-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [BUS_W-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [BUS_W-1:0] mem_rdata
);

    // Bus handshake: mem_req rises with stable we/addr/be/wdata and stays high until
    // mem_ack is sampled on a rising edge; that edge completes the transfer and
    // mem_rdata must be valid with it. mem_ack outside REQ has no effect.
    lsu_state_t       state;
    logic [BUS_W-1:0] addr_q;
    logic [BUS_W-1:0] wdata_q;
    logic [1:0]       size_q;
    logic             unsigned_q;
    logic             we_q;
    logic [4:0]       rd_sel_q;
    logic [7:0]       tmo_cnt;

    logic             accept;
    logic [3:0]       be_c;
    logic [BUS_W-1:0] wdata_c;
    logic [BUS_W-1:0] load_c;

    assign accept = start && (data_r ^ data_w);
    assign busy   = (state != LSU_IDLE);

    lsu_align u_align (
        .addr_lo        (addr_q[1:0]),
        .size           (size_q),
        .unsigned_value (unsigned_q),
        .wdata          (wdata_q),
        .rdata          (mem_rdata),
        .be             (be_c),
        .wdata_rep      (wdata_c),
        .rdata_ext      (load_c)
    );

    // Bus qualifiers are gated by mem_req so they read zero whenever no access is live.
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : '0;
    assign mem_be    = mem_req ? be_c : 4'b0000;
    assign mem_wdata = mem_req ? wdata_c : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LSU_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= SIZE_B;
            unsigned_q <= 1'b0;
            we_q       <= 1'b0;
            rd_sel_q   <= '0;
            tmo_cnt    <= '0;
            mem_req    <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            rd_w       <= 1'b0;
            rd_sel_out <= '0;
            rd_data    <= '0;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            rd_w       <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (accept) begin
                        addr_q     <= addr;
                        wdata_q    <= wdata;
                        size_q     <= data_size;
                        unsigned_q <= unsigned_value;
                        we_q       <= data_w;
                        rd_sel_q   <= rd_sel;
                        tmo_cnt    <= '0;
                        if (is_misaligned(data_size, addr[1:0])) begin
                            state      <= LSU_FAULT;
                            misaligned <= 1'b1;
                        end else begin
                            state   <= LSU_REQ;
                            mem_req <= 1'b1;
                        end
                    end
                end
                LSU_REQ: begin
                    // Ack is tested first so it wins in the terminal-count cycle.
                    if (mem_ack) begin
                        state   <= LSU_DONE;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        tmo_cnt <= '0;
                        if (!we_q) begin
                            rd_data    <= load_c;
                            rd_sel_out <= rd_sel_q;
                            rd_w       <= (rd_sel_q != 5'd0);
                        end
                    end else if (tmo_cnt == 8'(BUS_TIMEOUT - 1)) begin
                        state   <= LSU_IDLE;
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                LSU_DONE:  state <= LSU_IDLE;
                LSU_FAULT: state <= LSU_IDLE;
                default:   state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (BUS_TIMEOUT=4): one task per scenario,
// inline checks against hand-computed values, one summary line at the end.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        data_r = 1'b0;
    logic        data_w = 1'b0;
    logic [1:0]  data_size = 2'b00;
    logic        unsigned_value = 1'b0;
    logic [4:0]  rd_sel = 5'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done, misaligned, bus_err, rd_w;
    logic [4:0]  rd_sel_out;
    logic [31:0] rd_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(.BUS_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_r(data_r), .data_w(data_w),
        .data_size(data_size), .unsigned_value(unsigned_value), .rd_sel(rd_sel),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .misaligned(misaligned),
        .bus_err(bus_err), .rd_w(rd_w), .rd_sel_out(rd_sel_out), .rd_data(rd_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Drives a one-cycle start around rising edge N; returns at the negedge of cycle N+1.
    task automatic issue(input logic r, input logic w, input logic [1:0] sz, input logic uns,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        start = 1'b1; data_r = r; data_w = w; data_size = sz;
        unsigned_value = uns; rd_sel = rd; addr = a; wdata = d;
        @(negedge clk);
        start = 1'b0; data_r = 1'b0; data_w = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if ({busy, done, misaligned, bus_err, rd_w, mem_req, mem_we} !== 7'd0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000000", {busy, done, misaligned, bus_err, rd_w, mem_req, mem_we});
        end
        n_checks++; if ({rd_data, mem_addr, mem_wdata, mem_be, rd_sel_out} !== 105'd0) begin
            n_fail++; $display("FAIL reset_buses: rd_data=%h mem_addr=%h mem_wdata=%h be=%b want all 0", rd_data, mem_addr, mem_wdata, mem_be);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lb;
        mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
        issue(1'b1, 1'b0, 2'b00, 1'b0, 5'd7, 32'h0000_0103, 32'd0);
        n_checks++; if (mem_req !== 1'b1 || mem_be !== 4'b1000 || mem_addr !== 32'h0000_0100 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL lb_req: req=%b be=%b addr=%h we=%b want 1 1000 00000100 0", mem_req, mem_be, mem_addr, mem_we);
        end
        @(negedge clk);
        n_checks++; if (done !== 1'b1 || rd_w !== 1'b1 || mem_req !== 1'b0 || rd_sel_out !== 5'd7) begin
            n_fail++; $display("FAIL lb_done: done=%b rd_w=%b req=%b rd=%0d want 1 1 0 7", done, rd_w, mem_req, rd_sel_out);
        end
        n_checks++; if (rd_data !== 32'hFFFF_FF80) begin
            n_fail++; $display("FAIL lb_data: got %h want ffffff80", rd_data);
        end
        mem_ack = 1'b0;
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || busy !== 1'b0 || rd_data !== 32'hFFFF_FF80) begin
            n_fail++; $display("FAIL lb_after: done=%b busy=%b rd_data=%h want 0 0 ffffff80", done, busy, rd_data);
        end
    endtask

    task automatic test_lhu_wait;
        int busy_cycles = 0;
        int done_at = 0;
        mem_rdata = 32'hBEEF_0000;
        issue(1'b1, 1'b0, 2'b01, 1'b1, 5'd3, 32'h0000_0202, 32'd0);
        for (int i = 1; i <= 8; i++) begin
            if (busy) busy_cycles++;
            if (done && done_at == 0) done_at = i;
            if (i == 5) begin
                n_checks++; if (rd_data !== 32'h0000_BEEF || rd_w !== 1'b1) begin
                    n_fail++; $display("FAIL lhu_data: rd_data=%h rd_w=%b want 0000beef 1", rd_data, rd_w);
                end
            end
            mem_ack = (i == 4);
            @(negedge clk);
        end
        mem_ack = 1'b0;
        n_checks++; if (busy_cycles != 5) begin
            n_fail++; $display("FAIL lhu_busy: got %0d cycles want 5", busy_cycles);
        end
        n_checks++; if (done_at != 5) begin
            n_fail++; $display("FAIL lhu_done_cycle: got %0d want 5", done_at);
        end
    endtask

    task automatic test_sb;
        issue(1'b0, 1'b1, 2'b00, 1'b0, 5'd9, 32'h0000_0001, 32'h0000_00A5);
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0010 || mem_addr !== 32'd0) begin
            n_fail++; $display("FAIL sb_req: req=%b we=%b be=%b addr=%h want 1 1 0010 00000000", mem_req, mem_we, mem_be, mem_addr);
        end
        n_checks++; if (mem_wdata !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL sb_wdata: got %h want a5a5a5a5", mem_wdata);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        n_checks++; if (done !== 1'b1 || rd_w !== 1'b0 || rd_data !== 32'h0000_BEEF) begin
            n_fail++; $display("FAIL sb_done: done=%b rd_w=%b rd_data=%h want 1 0 0000beef", done, rd_w, rd_data);
        end
        @(negedge clk);
    endtask

    task automatic test_sh_hi;
        issue(1'b0, 1'b1, 2'b01, 1'b0, 5'd0, 32'h0000_0042, 32'h1234_C0DE);
        n_checks++; if (mem_be !== 4'b1100 || mem_wdata !== 32'hC0DE_C0DE || mem_addr !== 32'h0000_0040) begin
            n_fail++; $display("FAIL sh_lanes: be=%b wdata=%h addr=%h want 1100 c0dec0de 00000040", mem_be, mem_wdata, mem_addr);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_misaligned;
        issue(1'b1, 1'b0, 2'b10, 1'b0, 5'd4, 32'h0000_0006, 32'd0);
        n_checks++; if (misaligned !== 1'b1 || mem_req !== 1'b0 || rd_w !== 1'b0) begin
            n_fail++; $display("FAIL lw_misaligned: mis=%b req=%b rd_w=%b want 1 0 0", misaligned, mem_req, rd_w);
        end
        @(negedge clk);
        n_checks++; if (misaligned !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_w !== 1'b0) begin
            n_fail++; $display("FAIL lw_mis_after: mis=%b busy=%b done=%b rd_w=%b want 0 0 0 0", misaligned, busy, done, rd_w);
        end
        issue(1'b1, 1'b0, 2'b11, 1'b0, 5'd4, 32'h0000_0000, 32'd0);
        n_checks++; if (misaligned !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL size11_fault: mis=%b req=%b want 1 0", misaligned, mem_req);
        end
        @(negedge clk);
    endtask

    task automatic test_ignored;
        issue(1'b1, 1'b1, 2'b10, 1'b0, 5'd4, 32'h0000_0010, 32'd0);
        n_checks++; if (busy !== 1'b0 || mem_req !== 1'b0 || misaligned !== 1'b0) begin
            n_fail++; $display("FAIL both_rw_ignored: busy=%b req=%b mis=%b want 0 0 0", busy, mem_req, misaligned);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        n_checks++; if (done !== 1'b0 || rd_w !== 1'b0) begin
            n_fail++; $display("FAIL idle_ack_ignored: done=%b rd_w=%b want 0 0", done, rd_w);
        end
    endtask

    task automatic test_rd_zero;
        mem_rdata = 32'h1234_5678;
        issue(1'b1, 1'b0, 2'b10, 1'b0, 5'd0, 32'h0000_0008, 32'd0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        n_checks++; if (done !== 1'b1 || rd_w !== 1'b0) begin
            n_fail++; $display("FAIL rd0_no_write: done=%b rd_w=%b want 1 0", done, rd_w);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        issue(1'b1, 1'b0, 2'b10, 1'b0, 5'd5, 32'h0000_0020, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            n_checks++; if (mem_req !== 1'b1 || bus_err !== 1'b0) begin
                n_fail++; $display("FAIL tmo_req_c%0d: req=%b err=%b want 1 0", i, mem_req, bus_err);
            end
            @(negedge clk);
        end
        n_checks++; if (bus_err !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL tmo_err: err=%b busy=%b req=%b done=%b want 1 0 0 0", bus_err, busy, mem_req, done);
        end
        @(negedge clk);
        n_checks++; if (bus_err !== 1'b0) begin
            n_fail++; $display("FAIL tmo_pulse: err=%b want 0", bus_err);
        end
    endtask

    task automatic test_ack_terminal;
        mem_rdata = 32'hCAFE_F00D;
        issue(1'b1, 1'b0, 2'b10, 1'b0, 5'd6, 32'h0000_0024, 32'd0);
        repeat (3) @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        n_checks++; if (done !== 1'b1 || bus_err !== 1'b0 || rd_data !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL ack_terminal: done=%b err=%b rd_data=%h want 1 0 cafef00d", done, bus_err, rd_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int stray = 0;
        mem_rdata = 32'h0000_00FF;
        issue(1'b1, 1'b0, 2'b00, 1'b1, 5'd8, 32'h0000_0030, 32'd0);
        n_checks++; if (mem_req !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre: req=%b want 1", mem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async: req=%b busy=%b want 0 0", mem_req, busy);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || rd_w || mem_req) stray++;
        end
        mem_ack = 1'b0;
        n_checks++; if (stray != 0) begin
            n_fail++; $display("FAIL rstmid_stray_ack: %0d cycles with done/rd_w/req want 0", stray);
        end
        mem_rdata = 32'h0000_7F00;
        mem_ack = 1'b1;
        issue(1'b1, 1'b0, 2'b00, 1'b0, 5'd2, 32'h0000_0041, 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        n_checks++; if (done !== 1'b1 || rd_w !== 1'b1 || rd_data !== 32'h0000_007F) begin
            n_fail++; $display("FAIL rstmid_restart: done=%b rd_w=%b rd_data=%h want 1 1 0000007f", done, rd_w, rd_data);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_lb;
        test_lhu_wait;
        test_sb;
        test_sh_hi;
        test_misaligned;
        test_ignored;
        test_rd_zero;
        test_timeout;
        test_ack_terminal;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
